// File: rtl/store_data_packer.sv
// store_data_packer: packs stores into word-aligned strobed bus writes through a small FIFO; define STORE_MISALIGN_TRAP_EN to drop misaligned stores
module store_data_packer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic [ADDR_W-1:0] bus_waddr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  output logic              misalign_err,
  output logic              busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
  } entry_t;
  entry_t          mem_q [DEPTH];
  entry_t          pkt, head;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            st_ready_q, accept, drop, push, pop;
  // lane placement: sub-word data is replicated so every strobed lane carries it
  always_comb begin
    pkt.addr = {st_addr[ADDR_W-1:2], 2'b00};
    pkt.data = st_size == 2'b00 ? {4{st_data[7:0]}} : st_size == 2'b01 ? {2{st_data[15:0]}} : st_data;
    pkt.strb = st_size == 2'b00 ? 4'b0001 << st_addr[1:0] : st_size == 2'b01 ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign_q;
  assign drop = (st_size == 2'b01 && st_addr[0]) || (st_size == 2'b10 && st_addr[1:0] != 2'b00) || st_size == 2'b11;
  // a dropped store still handshakes; flag it one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else misalign_q <= accept && drop;
  end
  assign misalign_err = misalign_q;
`else
  assign drop         = 1'b0;
  assign misalign_err = 1'b0;
`endif
  assign accept = st_valid && st_ready_q;
  assign push   = accept && !drop;
  assign pop    = bus_wvalid && bus_wready;
  // occupancy after this cycle's push/pop; ready is derived from it so it stays registered
  always_comb begin
    count_d = push && !pop ? count_q + CW'(1) : pop && !push ? count_q - CW'(1) : count_q;
  end
  // pointers, count and registered ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      st_ready_q <= 1'b1;
    end else begin
      wptr_q     <= push ? wptr_q + PW'(1) : wptr_q;
      rptr_q     <= pop ? rptr_q + PW'(1) : rptr_q;
      count_q    <= count_d;
      st_ready_q <= count_d < FULL;
    end
  end
  // storage needs no reset: the outputs are masked whenever the buffer is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= pkt;
  end
  assign head       = mem_q[rptr_q];
  assign st_ready   = st_ready_q;
  assign bus_wvalid = count_q != '0;
  assign busy       = bus_wvalid;
  assign bus_waddr  = bus_wvalid ? head.addr : '0;
  assign bus_wdata  = bus_wvalid ? head.data : '0;
  assign bus_wstrb  = bus_wvalid ? head.strb : '0;
endmodule

// File: doc/store_data_packer.md
# store_data_packer

Store-path narrowing unit between the EX/MEM pipeline stage and the SoC write bus. Converts a 32-bit register value plus access size and byte address into a word-aligned bus write with byte strobes and replicated lane data. This is the inverse of immediate/load widening. Writes are queued in a small FIFO so the pipeline can retire stores while the bus is stalled.

## Interface
- `DEPTH`, 2: write-buffer entries; power of two, ≥2.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `st_valid` in 1: store request from the MEM stage.
- `st_ready` out 1: buffer can accept a request this cycle.
- `st_addr` in ADDR_W: byte address.
- `st_data` in 32: register data, right-justified.
- `st_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `bus_wvalid` out 1: write transaction valid.
- `bus_wready` in 1: bus accepts the transaction.
- `bus_waddr` out ADDR_W: word-aligned address, low two bits always 0.
- `bus_wdata` out 32: lane-placed write data.
- `bus_wstrb` out 4: byte enables; bit i covers `bus_wdata[8i+7:8i]`.
- `misalign_err` out 1: one-cycle pulse when a request is dropped.
- `busy` out 1: buffer not empty.

## Operation
- Accept occurs when `st_valid && st_ready`. `st_ready` = (count < DEPTH) and is registered. It never depends combinationally on `bus_wready`.
- Packing is little-endian, with `a = st_addr[1:0]`:
  - byte: `wdata = {4{st_data[7:0]}}`, `wstrb = 4'b0001 << a`.
  - half: `wdata = {2{st_data[15:0]}}`, `wstrb = a[1] ? 4'b1100 : 4'b0011`.
  - word: `wdata = st_data`, `wstrb = 4'b1111`.
  - In all cases `waddr = {st_addr[ADDR_W-1:2], 2'b00}`.
- Packing happens at accept. The FIFO stores {waddr, wdata, wstrb}.
- FIFO is circular. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate count runs 0..DEPTH.
- Push and pop in the same cycle leaves count unchanged. A full FIFO cannot push, because `st_ready` is low.
- Bus handshake is valid/ready:
  - `bus_wvalid` = count≠0.
  - Address, data and strobe present the head entry and must stay stable while `bus_wvalid && !bus_wready`.
  - Pop on `bus_wvalid && bus_wready`.
- `busy` = count≠0.

## Timing
- Reset values: `st_ready` 1, `bus_wvalid` 0, `bus_waddr`/`bus_wdata`/`bus_wstrb` 0, `misalign_err` 0, `busy` 0. Pointers and count are 0.
- Latency: a store accepted at edge N drives `bus_wvalid` high after edge N (visible cycle N+1) when the FIFO was empty.
- Throughput is one store per cycle while `bus_wready` is held high. No bubbles at the wrap boundary.
- `st_ready` falls the cycle after count reaches DEPTH. It rises the cycle after a pop from full.
- Reset mid-transaction discards all buffered entries. `bus_wvalid` is low in the cycle after the reset edge, regardless of `bus_wready`.
- `misalign_err` asserts for exactly one cycle, in the cycle after the offending accept.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined: requests are dropped in three cases:
  - half with `a[0]=1`;
  - word with `a≠0`;
  - any `st_size=11`.
- A dropped request is still handshaken (it consumes the accept cycle) but is not pushed, and `misalign_err` pulses.
- `STORE_MISALIGN_TRAP_EN` undefined:
  - Misaligned low bits are ignored: half uses only `a[1]`; word ignores `a`.
  - `st_size=11` is packed as word.
  - Every accept is pushed and `misalign_err` is tied 0.

## Test plan
- Byte store: addr 0x1000_0003, data 0x1234_56AB -> waddr 0x1000_0000, wdata 0xABAB_ABAB, wstrb 0x8, one cycle after accept.
- Half store: addr 0x2002, data 0xDEAD_BEEF -> wdata 0xBEEF_BEEF, wstrb 0xC. Word at 0x2004 -> wstrb 0xF, data unchanged.
- Backpressure: `bus_wready`=0; push 2 words -> `st_ready` low after second accept, bus outputs stable. Raise `bus_wready` -> entries drain in order and `st_ready` returns high.
- Wrap: with `bus_wready`=1, stream 5 stores back-to-back -> 5 bus beats on consecutive cycles, order preserved, `busy` drops one cycle after the last pop.
- Misalign: half at 0x3001. With macro defined -> no bus beat and `misalign_err` pulses once. Without the macro -> beat issued with wstrb 0x3.
- Reset: assert `rst_n`=0 while `bus_wvalid`=1 and `bus_wready`=0 -> next cycle `bus_wvalid`=0, `busy`=0, `st_ready`=1.
